apu_length_sequencer: RTL and testbench
=======================================

// Module: apu_length_sequencer
// PURPOSE
//  Consumer of the 256 Hz APU step enable (clk256_en). Divides it into the 128 Hz sweep and
//  64 Hz envelope enables. Runs one channel's length counter, which disables the channel when
//  it expires. One instance per channel: ch1/2/4 use LEN_WIDTH=6, ch3 uses LEN_WIDTH=8.
// PARAMETERS
//  LEN_WIDTH  6  width of the length register field; max length = 2**LEN_WIDTH
// PORTS
//  clk            in   1            system clock; single clock domain
//  reset_n        in   1            asynchronous, active-low reset
//  clk256_en      in   1            one-cycle 256 Hz step pulse (qualifies clk)
//  length_load    in   1            one-cycle write strobe for length_data
//  length_data    in   LEN_WIDTH    register value; loaded length = 2**LEN_WIDTH - length_data
//  length_enable  in   1            level: length counting enabled (NRx4 bit 6)
//  trigger        in   1            one-cycle channel trigger strobe (NRx4 bit 7 write)
//  dac_on         in   1            level: channel DAC powered
//  sweep_clk_en   out  1            one-cycle pulse, 128 Hz
//  envelope_clk_en out 1            one-cycle pulse, 64 Hz
//  length_value   out  LEN_WIDTH+1  current remaining length, 0..2**LEN_WIDTH
//  channel_on     out  1            channel active status
// BEHAVIOUR
//  Reset (reset_n low, async): phase=0, length_value=0, channel_on=0, both pulse outputs=0.
//   State is released on the first clk edge after reset_n rises.
//  Phase counter: 2 bits. It increments (mod 4) on every cycle with clk256_en=1.
//   sweep_clk_en is a registered pulse, high the cycle after a tick whose pre-increment
//    phase is 1 or 3.
//   envelope_clk_en is a registered pulse, high the cycle after a tick whose pre-increment
//    phase is 3.
//   Each pulse lasts exactly 1 cycle. Latency from tick to pulse is 1 cycle.
//  Length counter: LEN_WIDTH+1 bits, never wraps. Priority per cycle, highest first:
//   1. length_load: length_value <= 2**LEN_WIDTH - length_data. length_data=0 loads the max.
//      channel_on is unchanged.
//   2. trigger: if length_value==0, length_value <= 2**LEN_WIDTH; else unchanged.
//      channel_on <= dac_on. Trigger suppresses a decrement in the same cycle.
//   3. Decrement: when clk256_en & length_enable & length_value!=0,
//      length_value <= length_value-1. If the result is 0, channel_on <= 0 on the same edge.
//  Load and trigger in the same cycle: the load value is used for the zero-check.
//   Example: length_data=0 with trigger gives 2**LEN_WIDTH.
//  dac_on low: channel_on <= 0 on the next edge. This overrides trigger. The length counter is
//   unaffected.
//  The counter holds at 0 when a tick arrives with length_value==0; no underflow.
//  length_enable=0 freezes the counter but does not clear channel_on.
//  Loading or triggering between ticks does not reset the phase counter.
//  The extra-length-clock quirk on enabling length mid-frame is NOT modelled.
// TESTING
//  1. Release reset, apply 8 ticks -> sweep_clk_en pulses 4x, each 1 cycle after ticks 2,4,6,8;
//     envelope_clk_en pulses 2x, after ticks 4 and 8.
//  2. LEN_WIDTH=6: load 62, trigger with dac_on=1, length_enable=1 -> length_value=2,
//     channel_on=1. After 1 tick -> 1. After 2nd tick -> 0, channel_on=0 on that edge.
//  3. Trigger with length_value=0 -> length_value=64. LEN_WIDTH=8 instance -> 256.
//  4. length_load (data=10) and clk256_en in the same cycle -> length_value=54, no decrement.
//     Trigger and tick together -> no decrement.
//  5. dac_on=0 during trigger -> channel_on stays 0, length still reloads.
//     Dropping dac_on while active -> channel_on=0 next cycle.
//  6. Assert reset_n low mid-count (value 30, phase 2), asynchronously between edges -> all
//     outputs 0 immediately. After release, the first tick gives no sweep pulse.

Source files
------------

// File: rtl/apu_length_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | apu_length_sequencer_if                                                 |
// | Control inputs and status outputs of one APU channel length sequencer.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface apu_length_sequencer_if #(
   parameter int LEN_WIDTH = 6
);
   logic                 clk256_en;
   logic                 length_load;
   logic [LEN_WIDTH-1:0] length_data;
   logic                 length_enable;
   logic                 trigger;
   logic                 dac_on;
   logic                 sweep_clk_en;
   logic                 envelope_clk_en;
   logic [LEN_WIDTH:0]   length_value;
   logic                 channel_on;

   modport master (
      output clk256_en, length_load, length_data, length_enable, trigger, dac_on,
      input  sweep_clk_en, envelope_clk_en, length_value, channel_on
   );

   modport slave (
      input  clk256_en, length_load, length_data, length_enable, trigger, dac_on,
      output sweep_clk_en, envelope_clk_en, length_value, channel_on
   );
endinterface
`default_nettype wire

// File: rtl/apu_length_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | apu_length_sequencer                                                    |
// | 256 Hz step divider (sweep/envelope enables) and channel length counter.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module apu_length_sequencer #(
   parameter int LEN_WIDTH = 6
) (
   input  wire logic               clk,
   input  wire logic               reset_n,
   apu_length_sequencer_if.slave   bus
);
   localparam logic [LEN_WIDTH:0] c_len_max = {1'b1, {LEN_WIDTH{1'b0}}};

   logic [1:0]         phase_q,    phase_d;
   logic               sweep_q,    sweep_d;
   logic               envelope_q, envelope_d;
   logic [LEN_WIDTH:0] length_q,   length_d;
   logic               chan_on_q,  chan_on_d;
   logic [LEN_WIDTH:0] w_load_val;

   // length_data=0 wraps naturally to the full 2**LEN_WIDTH length
   assign w_load_val = c_len_max - {1'b0, bus.length_data};

   always_comb begin
      phase_d    = phase_q;
      sweep_d    = 1'b0;
      envelope_d = 1'b0;
      if (bus.clk256_en) begin
         phase_d    = phase_q + 2'd1;
         sweep_d    = phase_q[0];
         envelope_d = (phase_q == 2'd3);
      end
   end

   always_comb begin
      length_d  = length_q;
      chan_on_d = chan_on_q;
      if (bus.length_load || bus.trigger) begin
         if (bus.length_load)
            length_d = w_load_val;
         if (bus.trigger) begin
            // zero-check sees the freshly loaded value when both strobes coincide
            if (!bus.length_load && length_q == '0)
               length_d = c_len_max;
            chan_on_d = bus.dac_on;
         end
      end else if (bus.clk256_en && bus.length_enable && length_q != '0) begin
         length_d = length_q - 1'b1;
         if (length_q == {{LEN_WIDTH{1'b0}}, 1'b1})
            chan_on_d = 1'b0;
      end
      if (!bus.dac_on)
         chan_on_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= 2'd0;
         sweep_q    <= 1'b0;
         envelope_q <= 1'b0;
         length_q   <= '0;
         chan_on_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         sweep_q    <= sweep_d;
         envelope_q <= envelope_d;
         length_q   <= length_d;
         chan_on_q  <= chan_on_d;
      end
   end

   assign bus.sweep_clk_en    = sweep_q;
   assign bus.envelope_clk_en = envelope_q;
   assign bus.length_value    = length_q;
   assign bus.channel_on      = chan_on_q;
endmodule
`default_nettype wire

// File: tb/tb_apu_length_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_apu_length_sequencer                                                 |
// | Vector-table bench for the 6-bit instance plus an 8-bit instance.       |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_apu_length_sequencer;
   typedef struct {
      logic       tick;
      logic       load;
      logic [5:0] data;
      logic       len_en;
      logic       trig;
      logic       dac;
      logic       sweep;
      logic       env;
      logic [6:0] len;
      logic       on;
   } vec_t;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_err;
   vec_t vq[$];

   apu_length_sequencer_if #(.LEN_WIDTH(6)) if6 ();
   apu_length_sequencer_if #(.LEN_WIDTH(8)) if8 ();

   apu_length_sequencer #(.LEN_WIDTH(6)) u_dut6 (.clk(clk), .reset_n(reset_n), .bus(if6));
   apu_length_sequencer #(.LEN_WIDTH(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic tick, logic load, logic [5:0] data, logic len_en,
                               logic trig, logic dac, logic sweep, logic env,
                               logic [6:0] len, logic on);
      vec_t v;
      v.tick = tick; v.load = load; v.data = data; v.len_en = len_en;
      v.trig = trig; v.dac = dac; v.sweep = sweep; v.env = env; v.len = len; v.on = on;
      return v;
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got sweep=%b env=%b len=%0d on=%b, expected sweep=%b env=%b len=%0d on=%b",
                  name, act[11], act[10], act[9:1], act[0], exp[11], exp[10], exp[9:1], exp[0]);
      end
   endtask

   function automatic logic [11:0] pack6();
      return {if6.sweep_clk_en, if6.envelope_clk_en, 2'b00, if6.length_value, if6.channel_on};
   endfunction

   function automatic logic [11:0] pack8();
      return {if8.sweep_clk_en, if8.envelope_clk_en, if8.length_value, if8.channel_on};
   endfunction

   task automatic apply(input string name, input vec_t v);
      if6.clk256_en     = v.tick;
      if6.length_load   = v.load;
      if6.length_data   = v.data;
      if6.length_enable = v.len_en;
      if6.trigger       = v.trig;
      if6.dac_on        = v.dac;
      @(posedge clk);
      #1;
      check(name, pack6(), {v.sweep, v.env, 2'b00, v.len, v.on});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      if6.clk256_en = 0; if6.length_load = 0; if6.length_data = '0;
      if6.length_enable = 0; if6.trigger = 0; if6.dac_on = 0;
      if8.clk256_en = 0; if8.length_load = 0; if8.length_data = '0;
      if8.length_enable = 0; if8.trigger = 0; if8.dac_on = 0;

      // 8 ticks interleaved with idle cycles: each pulse must last exactly one cycle
      for (int i = 1; i <= 8; i++) begin
         vq.push_back(mk(1, 0, 0, 0, 0, 1, (i % 2) == 0, (i % 4) == 0, 0, 0));
         vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      // load 62 -> 2, trigger, count down to 0, hold at 0
      vq.push_back(mk(0, 1, 62, 1, 0, 1, 0, 0, 2, 0));
      vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 0, 2, 1));
      vq.push_back(mk(1, 0, 0,  1, 0, 1, 0, 0, 1, 1));
      vq.push_back(mk(0, 0, 0,  1, 0, 1, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 0, 0));
      vq.push_back(mk(1, 0, 0,  1, 0, 1, 0, 0, 0, 0));
      // trigger at zero reloads the maximum
      vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 0, 64, 1));
      // load+tick, trigger+tick: no decrement; then a plain decrement; then frozen
      vq.push_back(mk(1, 1, 10, 1, 0, 1, 1, 1, 54, 1));
      vq.push_back(mk(1, 0, 0,  1, 1, 1, 0, 0, 54, 1));
      vq.push_back(mk(1, 0, 0,  1, 0, 1, 1, 0, 53, 1));
      vq.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 53, 1));
      // dac_on handling, load+trigger with data 0
      vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 53, 0));
      vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 53, 0));
      vq.push_back(mk(0, 1, 0,  1, 1, 0, 0, 0, 64, 0));
      vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 0, 64, 1));
      vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 64, 0));
      vq.push_back(mk(0, 1, 63, 1, 0, 1, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 0, 1, 1));
      vq.push_back(mk(1, 0, 0,  1, 0, 1, 1, 1, 0, 0));
      vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 64, 0));
      // set up length 30, phase 2, sweep pulse high for the async-reset check
      vq.push_back(mk(0, 1, 34, 1, 1, 1, 0, 0, 30, 1));
      vq.push_back(mk(1, 0, 0,  0, 0, 1, 0, 0, 30, 1));
      vq.push_back(mk(1, 0, 0,  0, 0, 1, 1, 0, 30, 1));

      repeat (3) @(posedge clk);
      #1;
      check("reset6", pack6(), 12'h000);
      check("reset8", pack8(), 12'h000);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

      // asynchronous reset between edges clears outputs at once
      if6.clk256_en = 0;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset6", pack6(), 12'h000);
      @(negedge clk);
      reset_n = 1'b1;
      apply("post_reset_tick1", mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      apply("post_reset_tick2", mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
      if6.clk256_en = 0;

      // 8-bit instance: trigger at zero -> 256, decrement, load 200 -> 56
      if8.trigger = 1; if8.dac_on = 1; if8.length_enable = 1;
      @(posedge clk); #1;
      check("len8_trigger", pack8(), {2'b00, 9'd256, 1'b1});
      if8.trigger = 0; if8.clk256_en = 1;
      @(posedge clk); #1;
      check("len8_decrement", pack8(), {2'b00, 9'd255, 1'b1});
      if8.clk256_en = 0; if8.length_load = 1; if8.length_data = 8'd200;
      @(posedge clk); #1;
      check("len8_load", pack8(), {2'b00, 9'd56, 1'b1});
      if8.length_load = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
